// File: rtl/l1_inv_queue.sv
// l1_inv_queue
//   Buffers cache-line invalidations from an upstream agent and replays them
//   one at a time to the L1 tag array. Offers hitting a line already queued
//   (and not yet handed to the tags) are merged instead of stored twice. A
//   maintenance clear is forwarded to the tags only when no invalidation is
//   pending.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   i_inv_valid    upstream offers an invalidation this cycle
//   i_inv_adr      byte address of the line to invalidate
//   o_inv_stall    queue full; the current offer is not taken
//   o_tag_inv_req  invalidation request to the tags (head entry)
//   o_tag_inv_adr  address of the head entry
//   i_tag_inv_ack  tags finished the invalidation (1-cycle pulse)
//   i_clr_req      maintenance clear request, level, held until o_clr_ack
//   o_clr_ack      clear complete (1-cycle pulse)
//   o_tag_clr_req  clear request to the tags
//   i_tag_clr_ack  tags finished the clear (1-cycle pulse)
//   o_empty        no queued entries
//   o_coalesced    1-cycle pulse: last accepted offer merged into an entry

module l1_inv_queue #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inv_valid,
    input  logic [31:0] i_inv_adr,
    output logic        o_inv_stall,
    output logic        o_tag_inv_req,
    output logic [31:0] o_tag_inv_adr,
    input  logic        i_tag_inv_ack,
    input  logic        i_clr_req,
    output logic        o_clr_ack,
    output logic        o_tag_clr_req,
    input  logic        i_tag_clr_ack,
    output logic        o_empty,
    output logic        o_coalesced
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        INV_ISSUE = 3'b010,
        CLR_ISSUE = 3'b100
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  coalesced_q;

    logic [DEPTH_LOG2-1:0] rel_pos [DEPTH];
    logic [DEPTH-1:0]      hit;
    logic                  accept;
    logic                  match;
    logic                  push;
    logic                  pop;

    // ------------------------------------------------------------------
    // Coalescing lookup
    // ------------------------------------------------------------------
    // A slot holds a live entry when its distance from the head is below
    // count. The head is left out while it is being issued: the tags may
    // already have sampled it, so a new offer for that line must be kept.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel_pos[i] = DEPTH_LOG2'(i) - rd_ptr_q;
            if (({1'b0, rel_pos[i]} < count_q)
                && !((rel_pos[i] == '0) && (state_q == INV_ISSUE))
                && (mem[i][31:5] == i_inv_adr[31:5])) begin
                hit[i] = 1'b1;
            end
        end
    end

    assign match  = |hit;
    assign accept = i_inv_valid & ~o_inv_stall;
    assign push   = accept & ~match;
    assign pop    = (state_q == INV_ISSUE) & i_tag_inv_ack;

    // ------------------------------------------------------------------
    // Pointers, occupancy and merge pulse
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            coalesced_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // Push and pop in the same cycle cancel out in the count.
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            coalesced_q <= accept & match;
        end
    end

    // NOTE: the entry storage has no reset; the count qualifies every read,
    // so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_inv_adr;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every request state returns to IDLE on its ack, which guarantees at
    // least one low cycle on the request lines between transactions.
    // NOTE: state_d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = INV_ISSUE;
                end else if (i_clr_req) begin
                    state_d = CLR_ISSUE;
                end
            end
            INV_ISSUE: begin
                if (i_tag_inv_ack) begin
                    state_d = IDLE;
                end
            end
            CLR_ISSUE: begin
                if (i_tag_clr_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_tag_inv_req = (state_q == INV_ISSUE);
        o_tag_clr_req = (state_q == CLR_ISSUE);
        o_clr_ack     = (state_q == CLR_ISSUE) & i_tag_clr_ack;
    end

    // The head only advances on an ack, so the address is stable while the
    // request is high.
    assign o_tag_inv_adr = mem[rd_ptr_q];
    assign o_inv_stall   = (count_q == FULL_COUNT);
    assign o_empty       = (count_q == '0);
    assign o_coalesced   = coalesced_q;

endmodule

// File: tb/tb_l1_inv_queue.sv
// Testbench for l1_inv_queue: directed scenarios followed by a randomized
// phase. A queue-level reference model predicts occupancy, merges and the
// order of tag requests; a monitor compares the DUT against it every cycle.

module tb_l1_inv_queue;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_inv_valid;
    logic [31:0] i_inv_adr;
    logic        o_inv_stall;
    logic        o_tag_inv_req;
    logic [31:0] o_tag_inv_adr;
    logic        i_tag_inv_ack;
    logic        i_clr_req;
    logic        o_clr_ack;
    logic        o_tag_clr_req;
    logic        i_tag_clr_ack;
    logic        o_empty;
    logic        o_coalesced;

    always #5 clk = ~clk;

    l1_inv_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_inv_valid   (i_inv_valid),
        .i_inv_adr     (i_inv_adr),
        .o_inv_stall   (o_inv_stall),
        .o_tag_inv_req (o_tag_inv_req),
        .o_tag_inv_adr (o_tag_inv_adr),
        .i_tag_inv_ack (i_tag_inv_ack),
        .i_clr_req     (i_clr_req),
        .o_clr_ack     (o_clr_ack),
        .o_tag_clr_req (o_tag_clr_req),
        .i_tag_clr_ack (i_tag_clr_ack),
        .o_empty       (o_empty),
        .o_coalesced   (o_coalesced)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: list of queued addresses plus what the tags are
    // currently being asked to do.
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_INV, M_CLR} mstate_e;

    logic [31:0] m_q[$];     // queued invalidations, head first
    logic [31:0] exp_q[$];   // scoreboard: tag requests expected, in order
    mstate_e     m_state;
    bit          m_coal;

    always @(posedge clk or posedge rst) begin : model
        bit      full;
        bit      acc;
        bit      hit;
        bit      pop;
        int      first;
        mstate_e nxt;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_state = M_IDLE;
            m_coal  = 1'b0;
        end else begin
            full  = (m_q.size() == DEPTH);
            acc   = i_inv_valid && !full;
            first = (m_state == M_INV) ? 1 : 0;
            hit   = 1'b0;
            for (int k = first; k < m_q.size(); k++) begin
                if (m_q[k][31:5] == i_inv_adr[31:5]) hit = 1'b1;
            end
            pop = (m_state == M_INV) && i_tag_inv_ack;
            case (m_state)
                M_IDLE:  nxt = (m_q.size() != 0) ? M_INV : (i_clr_req ? M_CLR : M_IDLE);
                M_INV:   nxt = i_tag_inv_ack ? M_IDLE : M_INV;
                default: nxt = i_tag_clr_ack ? M_IDLE : M_CLR;
            endcase
            if (pop) void'(m_q.pop_front());
            if (acc && !hit) begin
                m_q.push_back(i_inv_adr);
                exp_q.push_back(i_inv_adr);
            end
            m_coal  = acc && hit;
            m_state = nxt;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge
    // ------------------------------------------------------------------
    bit          prev_inv_req = 1'b0;
    bit          prev_clr_req = 1'b0;
    bit          clr_ack_seen = 1'b0;
    logic [31:0] cur_adr      = '0;
    int          n_inv_req    = 0;
    int          n_clr_ack    = 0;
    int          inv_at_clr   = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_inv_req = 1'b0;
            prev_clr_req = 1'b0;
            clr_ack_seen = 1'b0;
        end else begin
            check("stall",     o_inv_stall,   m_q.size() == DEPTH);
            check("empty",     o_empty,       m_q.size() == 0);
            check("coalesced", o_coalesced,   m_coal);
            check("inv_req",   o_tag_inv_req, m_state == M_INV);
            check("clr_req",   o_tag_clr_req, m_state == M_CLR);
            check("clr_ack",   o_clr_ack,     (m_state == M_CLR) && i_tag_clr_ack);
            if (o_tag_inv_req && !prev_inv_req) begin
                n_inv_req++;
                check("sb_has_entry", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur_adr = exp_q.pop_front();
                    check("inv_adr", o_tag_inv_adr, cur_adr);
                end
            end else if (o_tag_inv_req) begin
                check("inv_adr_stable", o_tag_inv_adr, cur_adr);
            end
            if (o_tag_clr_req && !prev_clr_req) inv_at_clr = n_inv_req;
            if (o_clr_ack) n_clr_ack++;
            clr_ack_seen = o_clr_ack;
            prev_inv_req = o_tag_inv_req;
            prev_clr_req = o_tag_clr_req;
        end
    end

    // ------------------------------------------------------------------
    // Tag array responder
    // ------------------------------------------------------------------
    bit hold_inv = 1'b0;
    bit hold_clr = 1'b0;
    bit stray_en = 1'b0;
    int fix_dly  = 0;     // fixed ack delay in cycles, -1 for random

    initial begin : tags
        int inv_cnt = 0;
        int inv_dly = 0;
        int clr_cnt = 0;
        int clr_dly = 0;
        i_tag_inv_ack = 1'b0;
        i_tag_clr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_tag_inv_ack = 1'b0;
            i_tag_clr_ack = 1'b0;
            if (!rst) begin
                if (o_tag_inv_req) begin
                    if (inv_cnt == 0) inv_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                    if (!hold_inv && inv_cnt >= inv_dly) begin
                        i_tag_inv_ack = 1'b1;
                        inv_cnt = 0;
                    end else begin
                        inv_cnt++;
                    end
                end else begin
                    inv_cnt = 0;
                    if (stray_en && $urandom_range(0, 9) == 0) i_tag_inv_ack = 1'b1;
                end
                if (o_tag_clr_req) begin
                    if (clr_cnt == 0) clr_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 3));
                    if (!hold_clr && clr_cnt >= clr_dly) begin
                        i_tag_clr_ack = 1'b1;
                        clr_cnt = 0;
                    end else begin
                        clr_cnt++;
                    end
                end else begin
                    clr_cnt = 0;
                    if (stray_en && $urandom_range(0, 9) == 0) i_tag_clr_ack = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // One clock: drive the offer, cross the edge, then release a clear
    // request that was acknowledged in the cycle just finished.
    task automatic cyc(input bit v, input logic [31:0] a);
        i_inv_valid = v;
        i_inv_adr   = a;
        @(posedge clk);
        #1;
        if (clr_ack_seen) i_clr_req = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (!(o_empty && !o_tag_inv_req && !o_tag_clr_req && !i_clr_req
                 && exp_q.size() == 0) && n < 200) begin
            cyc(1'b0, 32'h0);
            n++;
        end
        check(name, n < 200, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_inv_req"},   o_tag_inv_req, 1'b0);
        check({tag, "_clr_req"},   o_tag_clr_req, 1'b0);
        check({tag, "_clr_ack"},   o_clr_ack,     1'b0);
        check({tag, "_coalesced"}, o_coalesced,   1'b0);
        check({tag, "_stall"},     o_inv_stall,   1'b0);
        check({tag, "_empty"},     o_empty,       1'b1);
    endtask

    function automatic logic [31:0] rand_adr();
        logic [31:0] a;
        a = 32'h1000_0000 | (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
        return a;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int          base;
        int          clr_base;
        int          n;
        bit          s;
        rst         = 1'b1;
        i_inv_valid = 1'b0;
        i_inv_adr   = '0;
        i_clr_req   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;

        // Single invalidation, ack three cycles after the request.
        fix_dly = 3;
        cyc(1'b1, 32'h0000_1020);
        check("d1_req_low", o_tag_inv_req, 1'b0);
        check("d1_not_empty", o_empty, 1'b0);
        cyc(1'b0, 32'h0);
        check("d1_req_high", o_tag_inv_req, 1'b1);
        check("d1_adr", o_tag_inv_adr, 32'h0000_1020);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0);
            check("d1_req_held", o_tag_inv_req, 1'b1);
        end
        cyc(1'b0, 32'h0);
        check("d1_empty_after_ack", o_empty, 1'b1);
        check("d1_req_dropped", o_tag_inv_req, 1'b0);

        // Fill to capacity, fifth offer held off until one ack.
        fix_dly  = 0;
        hold_inv = 1'b1;
        base     = n_inv_req;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h0000_3000 + 32'(i * 32));
        check("d2_stall_full", o_inv_stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h0000_3080);
            check("d2_stall_held", o_inv_stall, 1'b1);
        end
        hold_inv = 1'b0;
        n = 0;
        do begin
            s = o_inv_stall;
            cyc(1'b1, 32'h0000_3080);
            n++;
        end while (s && n < 10);
        check("d2_fifth_accepted", s, 1'b0);
        drain("d2_drain");
        check("d2_req_count", n_inv_req - base, 5);

        // Two offers to the same line before issue merge into one request.
        hold_inv = 1'b1;
        base     = n_inv_req;
        cyc(1'b1, 32'h0000_2040);
        cyc(1'b1, 32'h0000_205C);
        check("d3_coalesced_pulse", o_coalesced, 1'b1);
        cyc(1'b0, 32'h0);
        check("d3_coalesced_end", o_coalesced, 1'b0);
        hold_inv = 1'b0;
        drain("d3_drain");
        check("d3_single_req", n_inv_req - base, 1);

        // Clear requested with two entries pending: invalidations go first.
        hold_inv = 1'b1;
        base     = n_inv_req;
        clr_base = n_clr_ack;
        cyc(1'b1, 32'h0000_4000);
        cyc(1'b1, 32'h0000_4020);
        i_clr_req = 1'b1;
        cyc(1'b0, 32'h0);
        hold_inv = 1'b0;
        drain("d4_drain");
        check("d4_inv_before_clr", inv_at_clr - base, 2);
        check("d4_clr_ack_count", n_clr_ack - clr_base, 1);

        // Offer during an outstanding clear is held until the clear ends.
        hold_clr  = 1'b1;
        i_clr_req = 1'b1;
        n = 0;
        while (!o_tag_clr_req && n < 10) begin
            cyc(1'b0, 32'h0);
            n++;
        end
        check("d5_clr_issued", o_tag_clr_req, 1'b1);
        base     = n_inv_req;
        clr_base = n_clr_ack;
        cyc(1'b1, 32'h0000_5000);
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        check("d5_inv_waits", o_tag_inv_req, 1'b0);
        check("d5_entry_held", o_empty, 1'b0);
        hold_clr = 1'b0;
        drain("d5_drain");
        check("d5_inv_after_clr", n_inv_req - base, 1);
        check("d5_clr_ack_count", n_clr_ack - clr_base, 1);

        // Reset while an invalidation is outstanding.
        hold_inv = 1'b1;
        cyc(1'b1, 32'h0000_6000);
        cyc(1'b1, 32'h0000_6020);
        check("d6_inv_busy", o_tag_inv_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset("d6_rst");
        cyc(1'b0, 32'h0);
        rst      = 1'b0;
        hold_inv = 1'b0;
        cyc(1'b0, 32'h0);
        cyc(1'b0, 32'h0);
        check("d6_discarded", o_tag_inv_req, 1'b0);
        check("d6_empty", o_empty, 1'b1);

        // Randomized traffic with stray acks and random clear requests.
        fix_dly  = -1;
        stray_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!i_clr_req && $urandom_range(0, 49) == 0) i_clr_req = 1'b1;
            hold_inv = ($urandom_range(0, 7) == 0);
            cyc(($urandom_range(0, 9) < 7), rand_adr());
        end
        stray_en = 1'b0;
        hold_inv = 1'b0;
        drain("rand_drain");
        check("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l1_inv_queue.md
L1_INV_QUEUE -- requirements
Module: l1_inv_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2, log2 of queue depth (DEPTH = 4 by default).
REQ-002 SHALL have clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have i_inv_valid  input  1  upstream invalidation offered this cycle.
REQ-005 SHALL have i_inv_adr  input  32  byte address to invalidate.
REQ-006 SHALL have o_inv_stall  output  1  queue full; offer not accepted.
REQ-007 SHALL have o_tag_inv_req  output  1  invalidation request to L1 tags.
REQ-008 SHALL have o_tag_inv_adr  output  32  address of head entry.
REQ-009 SHALL have i_tag_inv_ack  input  1  tags completed the invalidation (1-cycle pulse).
REQ-010 SHALL have i_clr_req  input  1  maintenance clear request, level, held until o_clr_ack.
REQ-011 SHALL have o_clr_ack  output  1  clear complete, 1-cycle pulse.
REQ-012 SHALL have o_tag_clr_req  output  1  clear request to L1 tags.
REQ-013 SHALL have i_tag_clr_ack  input  1  tags clear complete (1-cycle pulse).
REQ-014 SHALL have o_empty  output  1  no queued entries.
REQ-015 SHALL have o_coalesced  output  1  1-cycle pulse: accepted offer merged with an existing entry.

Function
REQ-016 SHALL accept an offer when i_inv_valid & ~o_inv_stall; o_inv_stall = (count == DEPTH), from registers only, even if a pop occurs that cycle.
REQ-017 SHALL store entries in a FIFO of DEPTH x 32 bits, wrap-around pointers of DEPTH_LOG2 bits, count of DEPTH_LOG2+1 bits.
REQ-018 SHALL coalesce an accepted offer whose adr[31:5] equals a valid entry's adr[31:5], excluding the head while in InvIssue: no push, o_coalesced=1 the following cycle.
REQ-019 SHALL implement FSM states Idle, InvIssue, ClrIssue; one-hot encoding.
REQ-020 Idle: count!=0 -> InvIssue; else i_clr_req -> ClrIssue; else Idle (invalidations have priority over clear).
REQ-021 InvIssue: i_tag_inv_ack -> Idle and pop head on that edge; else hold.
REQ-022 ClrIssue: i_tag_clr_ack -> Idle; else hold; pushes remain allowed in ClrIssue.
REQ-023 o_tag_inv_req = (state_q==InvIssue); o_tag_inv_adr = head entry, stable while req high.
REQ-024 o_tag_clr_req = (state_q==ClrIssue); o_clr_ack = (state_q==ClrIssue) & i_tag_clr_ack.
REQ-025 Every tag request SHALL be low for at least one cycle (Idle) after each ack, so tags never re-sample a stale request.
REQ-026 Issue latency: entry pushed into empty queue in Idle at edge N -> o_tag_inv_req high from cycle N+2.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and both take effect.
REQ-028 Acks arriving in a state not expecting them SHALL be ignored.
REQ-029 o_empty = (count == 0).

Reset
REQ-030 On rst: state Idle, pointers and count 0, o_tag_inv_req=0, o_tag_clr_req=0, o_clr_ack=0, o_coalesced=0, o_inv_stall=0, o_empty=1; FIFO data not reset.
REQ-031 Reset mid-operation SHALL discard all queued entries and any in-flight request; tags block is reset alongside.

Verification
REQ-032 Push 0x0000_1020 into empty queue, ack 3 cycles after req -> req high 2 cycles after push, adr=0x0000_1020, o_empty=1 after ack edge.
REQ-033 Push 5 distinct lines back-to-back, no acks (DEPTH=4) -> o_inv_stall=1 after 4th, 5th held off; ack once -> 5th accepted, FIFO order preserved.
REQ-034 Push 0x0000_2040 then 0x0000_205C while first not issued -> one entry, o_coalesced pulse, single tag request.
REQ-035 i_clr_req with 2 queued entries -> both invalidations issued and acked first, then o_tag_clr_req; i_tag_clr_ack -> o_clr_ack same cycle.
REQ-036 Push during ClrIssue -> entry held, issued after clear ack; assert rst mid-InvIssue -> all outputs at reset values immediately, o_empty=1.
